// File: rtl/test_pattern_gen.sv
// test_pattern_gen
//
// Synthetic stand-in for the framebuffer pixel RAM. Answers ram_addr reads with one of
// several test patterns, with the same one-cycle registered read latency as the block RAM
// it replaces. Pattern changes are staged in pending registers and only become active on
// a slice boundary (position_sync), so a slice is never split between two patterns.
//
// Parameters:
//   ADDR_W      width of ram_addr
//   DATA_W      width of ram_rdata
//   WORDS_LOG2  log2 of words per slice; word index is ram_addr[WORDS_LOG2-1:0]
//   HOLD_SLICES position_sync pulses per walking-LED step (>= 1)
//   RESET_MODE  pattern active out of reset
//   RESET_ADDR  single-LED word index out of reset
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   mode          requested pattern: 0 OFF, 1 SINGLE, 2 WALK, 3 ALL_ON, 4 STRIPES,
//                 5 CHECKER, 6-7 reserved (read as zeros)
//   mode_load     strobe: capture mode and single_addr into the pending registers
//   single_addr   word lit in SINGLE mode
//   position_sync slice-boundary pulse; pending pattern becomes active
//   ram_addr      read address from the framebuffer
//   ram_rdata     registered read data, valid one cycle after ram_addr
//   active_mode   pattern currently applied
//   walk_idx      current walking-LED word

module test_pattern_gen #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WORDS_LOG2  = 4,
  parameter int unsigned HOLD_SLICES = 8,
  parameter int unsigned RESET_MODE  = 1,
  parameter int unsigned RESET_ADDR  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            mode,
  input  logic                  mode_load,
  input  logic [WORDS_LOG2-1:0] single_addr,
  input  logic                  position_sync,
  input  logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_rdata,
  output logic [2:0]            active_mode,
  output logic [WORDS_LOG2-1:0] walk_idx
);

  // Pattern encodings.
  localparam logic [2:0] ModeOff     = 3'd0;
  localparam logic [2:0] ModeSingle  = 3'd1;
  localparam logic [2:0] ModeWalk    = 3'd2;
  localparam logic [2:0] ModeAllOn   = 3'd3;
  localparam logic [2:0] ModeStripes = 3'd4;
  localparam logic [2:0] ModeChecker = 3'd5;

  // hold_cnt needs at least one bit even when HOLD_SLICES is 1.
  localparam int unsigned HoldW = (HOLD_SLICES > 1) ? $clog2(HOLD_SLICES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_SLICES - 1);

  localparam logic [2:0]            ResetModeVal = 3'(RESET_MODE);
  localparam logic [WORDS_LOG2-1:0] ResetAddrVal = WORDS_LOG2'(RESET_ADDR);

  logic [2:0]            pend_mode;
  logic [WORDS_LOG2-1:0] pend_addr;
  logic [WORDS_LOG2-1:0] lit_addr;
  logic [HoldW-1:0]      hold_cnt;
  logic                  parity;

  logic [2:0]            next_mode;
  logic [WORDS_LOG2-1:0] next_addr;
  logic [WORDS_LOG2-1:0] word;
  logic                  lit;
  logic [DATA_W-1:0]     rdata_d;

  // Upper address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^ram_addr[ADDR_W-1:WORDS_LOG2];

  assign word = ram_addr[WORDS_LOG2-1:0];

  // A load in the same cycle as the boundary bypasses the pending registers so the new
  // pattern applies at this boundary rather than the next one.
  always_comb begin
    next_mode = pend_mode;
    next_addr = pend_addr;
    if (mode_load) begin
      next_mode = mode;
      next_addr = single_addr;
    end
  end

  // Data function, evaluated with the state in effect during the address cycle.
  always_comb begin
    lit = 1'b0;
    case (active_mode)
      ModeOff:     lit = 1'b0;
      ModeSingle:  lit = (word == lit_addr);
      ModeWalk:    lit = (word == walk_idx);
      ModeAllOn:   lit = 1'b1;
      ModeStripes: lit = word[0];
      ModeChecker: lit = word[0] ^ parity;
      default:     lit = 1'b0;
    endcase
    rdata_d = lit ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mode   <= ResetModeVal;
      pend_addr   <= ResetAddrVal;
      active_mode <= ResetModeVal;
      lit_addr    <= ResetAddrVal;
      walk_idx    <= '0;
      hold_cnt    <= '0;
      parity      <= 1'b0;
      ram_rdata   <= '0;
    end else begin
      if (mode_load) begin
        pend_mode <= mode;
        pend_addr <= single_addr;
      end

      if (position_sync) begin
        active_mode <= next_mode;
        lit_addr    <= next_addr;
        parity      <= ~parity;
        if (next_mode == ModeWalk) begin
          if (active_mode != ModeWalk) begin
            // Entering WALK restarts the sequence from word 0.
            walk_idx <= '0;
            hold_cnt <= '0;
          end else if (hold_cnt == HoldLast) begin
            hold_cnt <= '0;
            walk_idx <= walk_idx + 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end

      ram_rdata <= rdata_d;
    end
  end

endmodule
